// File: rtl/dawson_if_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dawson_if_pkg
// Purpose : Shared types for the Dawson arithmetic unit user-side adapter.
//           Holds the adapter state encoding and the fixed data width.
// Revision: 1.0 - initial release
// ============================================================================
package dawson_if_pkg;

  localparam int unsigned DATA_W = 64;

  // RESET is encoded as all-zeros so a power-up register value of zero
  // already corresponds to the reset state.
  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_TX_A    = 3'd2,
    ST_TX_B    = 3'd3,
    ST_WAIT_RX = 3'd4,
    ST_RX      = 3'd5,
    ST_USER_RX = 3'd6
  } dawson_if_state_t;

endpackage
`default_nettype wire

// File: rtl/dawson_if.sv
`default_nettype none
// ============================================================================
// Module  : dawson_if
// Purpose : User-side adapter for the Dawson double-precision arithmetic unit.
//           Latches an operand pair on a one-cycle ready_in pulse, sends A then
//           B over the unit's strobe/ack handshake, waits for the result,
//           acknowledges it and presents it with a one-cycle ready_out pulse.
// Ports   :
//   clock, reset_n          - system clock, async active-low reset
//   a, b, ready_in          - user operands and start pulse
//   out, ready_out          - user result and result-valid pulse
//   clk, rst                - clock and active-high reset forwarded to unit
//   input_a/_stb/_ack       - operand A handshake to the unit
//   input_b/_stb/_ack       - operand B handshake to the unit
//   output_z/_stb/_ack      - result handshake from the unit
// Revision: 1.0 - initial release
// ============================================================================
module dawson_if
  import dawson_if_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ready_in,
  output logic [DATA_W-1:0] out,
  output logic              ready_out,
  output logic              clk,
  output logic              rst,
  output logic [DATA_W-1:0] input_a,
  output logic              input_a_stb,
  input  logic              input_a_ack,
  output logic [DATA_W-1:0] input_b,
  output logic              input_b_stb,
  input  logic              input_b_ack,
  input  logic [DATA_W-1:0] output_z,
  input  logic              output_z_stb,
  output logic              output_z_ack
);

  dawson_if_state_t  state;
  dawson_if_state_t  state_next;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;

  // Each state only looks at the one handshake input it is waiting on, so
  // early or stray acks/strobes are ignored.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_RESET:   state_next = ST_IDLE;
      ST_IDLE:    if (ready_in)     state_next = ST_TX_A;
      ST_TX_A:    if (input_a_ack)  state_next = ST_TX_B;
      ST_TX_B:    if (input_b_ack)  state_next = ST_WAIT_RX;
      ST_WAIT_RX: if (output_z_stb) state_next = ST_RX;
      ST_RX:      state_next = ST_USER_RX;
      ST_USER_RX: state_next = ST_IDLE;
      default:    state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_RESET;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && ready_in) begin
        op_a <= a;
        op_b <= b;
      end
      if (state == ST_WAIT_RX && output_z_stb) begin
        result <= output_z;
      end
    end
  end

  // Moore outputs decoded from the registered state.
  assign input_a_stb  = (state == ST_TX_A);
  assign input_b_stb  = (state == ST_TX_B);
  assign output_z_ack = (state == ST_RX);
  assign ready_out    = (state == ST_USER_RX);

  assign input_a = op_a;
  assign input_b = op_b;
  assign out     = result;

  // The unit sees reset while reset_n is low and for the single cycle spent
  // in RESET after release, giving it one clean clock edge in reset.
  assign rst = (state == ST_RESET) || !reset_n;
  assign clk = clock;

endmodule
`default_nettype wire

// File: tb/tb_dawson_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_dawson_if
// Purpose : Self-checking bench for dawson_if. A behavioural Dawson unit
//           (adds its two operands) answers the handshakes; expected results
//           are queued on issue and compared when ready_out is presented.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dawson_if;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        ready_in = 1'b0;
  logic [63:0] out;
  logic        ready_out;
  logic        clk;
  logic        rst;
  logic [63:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [63:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [63:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  // Unit-side inputs come either from the directed sequence or the
  // behavioural core model.
  logic        auto_core = 1'b0;
  logic        dir_a_ack = 1'b0, dir_b_ack = 1'b0, dir_z_stb = 1'b0;
  logic [63:0] dir_z = '0;
  logic        core_a_ack = 1'b0, core_b_ack = 1'b0, core_z_stb = 1'b0;
  logic [63:0] core_z = '0;

  assign input_a_ack  = auto_core ? core_a_ack : dir_a_ack;
  assign input_b_ack  = auto_core ? core_b_ack : dir_b_ack;
  assign output_z_stb = auto_core ? core_z_stb : dir_z_stb;
  assign output_z     = auto_core ? core_z     : dir_z;

  int checks = 0;
  int failures = 0;
  int results_seen = 0;
  logic [63:0] sb_q[$];

  dawson_if dut (
    .clock(clock), .reset_n(reset_n), .a(a), .b(b), .ready_in(ready_in),
    .out(out), .ready_out(ready_out), .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Behavioural Dawson unit: accepts A, then B after random waits, then
  // returns A+B after a random delay and drops the strobe once acked.
  int a_wait = 0, b_wait = 0, z_wait = 0;
  logic        z_pending = 1'b0;
  logic [63:0] got_a = '0, z_val = '0;

  always @(negedge clock) begin
    if (auto_core) begin
      if (input_a_stb) begin
        if (a_wait == 0) begin core_a_ack = 1'b1; got_a = input_a; end
        else a_wait--;
      end else begin
        core_a_ack = 1'b0; a_wait = $urandom_range(0, 3);
      end
      if (input_b_stb) begin
        if (b_wait == 0) begin
          core_b_ack = 1'b1; z_val = got_a + input_b;
          z_pending = 1'b1; z_wait = $urandom_range(0, 4);
        end else b_wait--;
      end else begin
        core_b_ack = 1'b0; b_wait = $urandom_range(0, 3);
      end
      if (output_z_ack) core_z_stb = 1'b0;
      else if (z_pending) begin
        if (z_wait == 0) begin core_z = z_val; core_z_stb = 1'b1; z_pending = 1'b0; end
        else z_wait--;
      end
    end
  end

  // Monitor: protocol properties every cycle, result scoreboard on ready_out.
  logic prev_zack = 1'b0;
  always @(negedge clock) begin
    checks++;
    if (clk !== clock) begin
      failures++; $display("FAIL clk_copy: got %b expected %b", clk, clock);
    end
    checks++;
    if (input_a_stb && input_b_stb) begin
      failures++; $display("FAIL stb_exclusive: got a_stb=1 b_stb=1 expected not both");
    end
    if (reset_n) begin
      checks++;
      if (ready_out !== prev_zack) begin
        failures++;
        $display("FAIL ready_after_ack: got ready_out=%b expected %b", ready_out, prev_zack);
      end
      checks++;
      if (output_z_ack && prev_zack) begin
        failures++; $display("FAIL zack_single: got ack high 2 cycles expected 1");
      end
    end
    if (ready_out) begin
      results_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++; $display("FAIL result_unexpected: got 0x%016h expected no result", out);
      end else begin
        logic [63:0] exp_v;
        exp_v = sb_q.pop_front();
        if (out !== exp_v) begin
          failures++; $display("FAIL result: got 0x%016h expected 0x%016h", out, exp_v);
        end
      end
    end
    prev_zack = output_z_ack;
  end

  logic [63:0] rnd_a, rnd_b;
  int base, cyc;

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    chk("rst_in_reset", {63'd0, rst}, 64'd1);
    chk("a_stb_reset", {63'd0, input_a_stb}, 64'd0);
    chk("b_stb_reset", {63'd0, input_b_stb}, 64'd0);
    chk("zack_reset", {63'd0, output_z_ack}, 64'd0);
    chk("ready_reset", {63'd0, ready_out}, 64'd0);
    chk("out_reset", out, 64'd0);
    chk("clk_high", {63'd0, clk}, 64'd1);
    reset_n = 1'b1;
    #1 chk("rst_reset_state", {63'd0, rst}, 64'd1);
    tick();
    chk("rst_idle", {63'd0, rst}, 64'd0);

    // ---------------- full directed transaction a=1 b=2 ----------------
    a = 64'd1; b = 64'd2; ready_in = 1'b1; sb_q.push_back(64'd3);
    tick();
    ready_in = 1'b0; a = '1; b = '1;
    chk("a_stb_after_start", {63'd0, input_a_stb}, 64'd1);
    chk("input_a_latched", input_a, 64'd1);
    chk("zack_in_tx_a", {63'd0, output_z_ack}, 64'd0);
    // Delayed A ack with stray B ack and result strobe.
    dir_b_ack = 1'b1; dir_z_stb = 1'b1; dir_z = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_stb_held", {63'd0, input_a_stb}, 64'd1);
      chk("input_a_stable", input_a, 64'd1);
      chk("b_stb_ignored", {63'd0, input_b_stb}, 64'd0);
      chk("zack_ignored", {63'd0, output_z_ack}, 64'd0);
    end
    dir_b_ack = 1'b0; dir_z_stb = 1'b0; dir_a_ack = 1'b1;
    tick();
    dir_a_ack = 1'b0;
    chk("b_stb_tx_b", {63'd0, input_b_stb}, 64'd1);
    chk("a_stb_drop", {63'd0, input_a_stb}, 64'd0);
    chk("input_b_latched", input_b, 64'd2);
    dir_b_ack = 1'b1;
    tick();
    dir_b_ack = 1'b0;
    chk("b_stb_wait", {63'd0, input_b_stb}, 64'd0);
    ready_in = 1'b1;   // ignored outside IDLE
    tick();
    ready_in = 1'b0;
    chk("a_stb_wait_spurious", {63'd0, input_a_stb}, 64'd0);
    chk("zack_wait", {63'd0, output_z_ack}, 64'd0);
    dir_z = 64'd3; dir_z_stb = 1'b1;
    tick();
    dir_z_stb = 1'b0;
    chk("zack_rx", {63'd0, output_z_ack}, 64'd1);
    chk("ready_rx", {63'd0, ready_out}, 64'd0);
    tick();
    chk("ready_user", {63'd0, ready_out}, 64'd1);
    chk("out_user", out, 64'd3);
    chk("zack_user", {63'd0, output_z_ack}, 64'd0);
    tick();
    chk("ready_idle", {63'd0, ready_out}, 64'd0);
    chk("out_hold", out, 64'd3);

    // ---------------- mid-transaction reset ----------------
    a = 64'd5; b = 64'd6; ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    chk("a_stb_second", {63'd0, input_a_stb}, 64'd1);
    dir_a_ack = 1'b1;
    tick();
    dir_a_ack = 1'b0;
    chk("b_stb_second", {63'd0, input_b_stb}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("b_stb_async_drop", {63'd0, input_b_stb}, 64'd0);
    chk("rst_async", {63'd0, rst}, 64'd1);
    chk("out_cleared", out, 64'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rst_after_release", {63'd0, rst}, 64'd0);
    chk("out_after_release", out, 64'd0);
    chk("a_stb_after_release", {63'd0, input_a_stb}, 64'd0);

    // ---------------- randomized transactions ----------------
    auto_core = 1'b1;
    tick();
    for (int t = 0; t < 25; t++) begin
      rnd_a = {$urandom, $urandom};
      rnd_b = {$urandom, $urandom};
      if (t == 0) begin rnd_a = '1; rnd_b = 64'd1; end
      a = rnd_a; b = rnd_b; ready_in = 1'b1;
      sb_q.push_back(rnd_a + rnd_b);
      base = results_seen;
      tick();
      ready_in = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      cyc = 0;
      while (results_seen == base && cyc < 200) begin
        tick();
        cyc++;
      end
      checks++;
      if (results_seen == base) begin
        failures++;
        $display("FAIL txn_timeout: got no ready_out after %0d cycles expected one", cyc);
      end
      tick();
    end
    repeat (3) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
